// File: rtl/datamemory_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
// The master issues one request per cycle; the slave (the memory) returns
// load data with a valid pulse and flags rejected requests with misalign.
interface datamemory_sized_if #(
   parameter int data_WIDTH = 32,
   parameter int addr_WIDTH = 12
);
   logic                  cs;
   logic                  WR_RD;
   logic [1:0]            size;
   logic                  sign_ext;
   logic [addr_WIDTH-1:0] ADDR;
   logic [data_WIDTH-1:0] din;
   logic [data_WIDTH-1:0] dout;
   logic                  valid;
   logic                  misalign;

   modport master (
      output cs, WR_RD, size, sign_ext, ADDR, din,
      input  dout, valid, misalign
   );

   modport slave (
      input  cs, WR_RD, size, sign_ext, ADDR, din,
      output dout, valid, misalign
   );
endinterface

// File: rtl/datamemory_sized.sv
// Byte-addressed, little-endian data memory with byte/half/word access.
// Stores write only the selected byte lanes; loads are shifted down to bit 0
// and sign- or zero-extended. Load latency is 1 or 2 cycles, fully pipelined.
// Misaligned requests are dropped and reported with a one-cycle misalign pulse.
module datamemory_sized #(
   parameter int data_WIDTH = 32,
   parameter int addr_WIDTH = 12,
   parameter int READ_LAT   = 1
) (
   input logic               clk,
   input logic               rst,
   datamemory_sized_if.slave bus
);
   localparam int NLANES = data_WIDTH / 8;
   localparam int DEPTH  = 2 ** (addr_WIDTH - 2);

   logic [data_WIDTH-1:0] mem [DEPTH];

   logic [addr_WIDTH-3:0] widx;
   logic [1:0]            lane;
   logic                  aligned;
   logic                  accept;
   logic                  ld;
   logic                  st;
   logic [NLANES-1:0]     lane_we;
   logic [7:0]            lane_wd [NLANES];

   logic [data_WIDTH-1:0] dout_r;
   logic                  valid_r;
   logic                  misalign_r;

   // Pull the addressed field down to bit 0 and widen it; word loads pass through.
   function automatic logic [data_WIDTH-1:0] extend_load(
      input logic [data_WIDTH-1:0] raw,
      input logic [1:0]            ln,
      input logic [1:0]            sz,
      input logic                  sx
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = raw[{ln, 3'b000} +: 8];
      h = raw[{ln[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   extend_load = {{(data_WIDTH-8){sx & b[7]}}, b};
         2'b01:   extend_load = {{(data_WIDTH-16){sx & h[15]}}, h};
         default: extend_load = raw;
      endcase
   endfunction

   assign widx   = bus.ADDR[addr_WIDTH-1:2];
   assign lane   = bus.ADDR[1:0];
   assign accept = bus.cs & aligned;
   assign ld     = accept & bus.WR_RD;
   assign st     = accept & ~bus.WR_RD;

   // Alignment rule per access size; the reserved size never aligns.
   always_comb begin
      aligned = 1'b0;
      case (bus.size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~bus.ADDR[0];
         2'b10:   aligned = (bus.ADDR[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Byte-lane enables and lane data: narrow store data is replicated so each
   // enabled lane picks its byte from the right-justified din.
   always_comb begin
      for (int l = 0; l < NLANES; l++) begin
         lane_we[l] = 1'b0;
         lane_wd[l] = bus.din[8*l +: 8];
         case (bus.size)
            2'b00: begin
               lane_we[l] = (l[1:0] == lane);
               lane_wd[l] = bus.din[7:0];
            end
            2'b01: begin
               lane_we[l] = (l[1] == lane[1]);
               lane_wd[l] = bus.din[8*(l%2) +: 8];
            end
            2'b10:   lane_we[l] = 1'b1;
            default: lane_we[l] = 1'b0;
         endcase
      end
   end

   // Store commit: only enabled lanes of the addressed word are written.
   always_ff @(posedge clk) begin
      if (st) begin
         for (int l = 0; l < NLANES; l++) begin
            if (lane_we[l]) mem[widx][8*l +: 8] <= lane_wd[l];
         end
      end
   end

   // Rejected request is reported one cycle later, whatever its direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_r <= 1'b0;
      else     misalign_r <= bus.cs & ~aligned;
   end

   generate
      if (READ_LAT == 1) begin : g_lat1
         // Single stage: array read, extension and output register in one cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_r <= 1'b0;
               dout_r  <= '0;
            end else begin
               valid_r <= ld;
               if (ld) dout_r <= extend_load(mem[widx], lane, bus.size, bus.sign_ext);
            end
         end
      end else begin : g_lat2
         logic [data_WIDTH-1:0] raw_p1;
         logic [1:0]            lane_p1;
         logic [1:0]            size_p1;
         logic                  sx_p1;
         logic                  vld_p1;

         // Stage 1 data: raw word and the access attributes, captured on a load.
         always_ff @(posedge clk) begin
            if (ld) begin
               raw_p1  <= mem[widx];
               lane_p1 <= lane;
               size_p1 <= bus.size;
               sx_p1   <= bus.sign_ext;
            end
         end

         // Stage 1 control: reset drops any load in flight.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_p1 <= 1'b0;
            else     vld_p1 <= ld;
         end

         // Stage 2: extension and output register; dout holds between loads.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_r <= 1'b0;
               dout_r  <= '0;
            end else begin
               valid_r <= vld_p1;
               if (vld_p1) dout_r <= extend_load(raw_p1, lane_p1, size_p1, sx_p1);
            end
         end
      end
   endgenerate

   assign bus.dout     = dout_r;
   assign bus.valid    = valid_r;
   assign bus.misalign = misalign_r;
endmodule

// File: tb/tb_datamemory_sized.sv
// Bench for datamemory_sized: one instance with load latency 1 and one with
// latency 2 receive identical requests; results are compared against a
// byte-array model of the memory.
module tb_datamemory_sized;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int N  = 300;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   datamemory_sized_if #(.data_WIDTH(DW), .addr_WIDTH(AW)) bus1 ();
   datamemory_sized_if #(.data_WIDTH(DW), .addr_WIDTH(AW)) bus2 ();

   datamemory_sized #(.data_WIDTH(DW), .addr_WIDTH(AW), .READ_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));
   datamemory_sized #(.data_WIDTH(DW), .addr_WIDTH(AW), .READ_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2));

   int checks   = 0;
   int failures = 0;

   logic [7:0] mbytes [0:(1<<AW)-1];

   typedef struct packed {
      logic        v1, v2, m1, m2;
      logic [31:0] d1, d2;
   } obs_t;

   task automatic set_req(input logic c, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [AW-1:0] a, input logic [31:0] d);
      bus1.cs = c;  bus1.WR_RD = wr; bus1.size = sz; bus1.sign_ext = sx; bus1.ADDR = a; bus1.din = d;
      bus2.cs = c;  bus2.WR_RD = wr; bus2.size = sz; bus2.sign_ext = sx; bus2.ADDR = a; bus2.din = d;
   endtask

   task automatic idle();
      set_req(1'b0, 1'b1, 2'b00, 1'b0, '0, '0);
   endtask

   function automatic logic model_aligned(input logic [1:0] sz, input logic [AW-1:0] a);
      if (sz == 2'd0) return 1'b1;
      if (sz == 2'd1) return (a % 2) == 0;
      if (sz == 2'd2) return (a % 4) == 0;
      return 1'b0;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
      int n;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) mbytes[a + k] = d[8*k +: 8];
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [AW-1:0] a);
      logic [31:0] v;
      v = '0;
      if (sz == 2'd0) begin
         v[7:0] = mbytes[a];
         if (sx && v[7]) v[31:8] = '1;
      end else if (sz == 2'd1) begin
         v[15:0] = {mbytes[a + 1], mbytes[a]};
         if (sx && v[15]) v[31:16] = '1;
      end else begin
         v = {mbytes[a + 3], mbytes[a + 2], mbytes[a + 1], mbytes[a]};
      end
      return v;
   endfunction

   task automatic sample(output obs_t o);
      o.v1 = bus1.valid;    o.v2 = bus2.valid;
      o.m1 = bus1.misalign; o.m2 = bus2.misalign;
      o.d1 = bus1.dout;     o.d2 = bus2.dout;
   endtask

   // One request in the current cycle, then observe the next two cycles.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        output obs_t o1, output obs_t o2);
      set_req(1'b1, wr, sz, sx, a, d);
      if (!wr && model_aligned(sz, a)) model_store(sz, a, d);
      @(negedge clk);
      idle();
      sample(o1);
      @(negedge clk);
      sample(o2);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (bus1.dout !== 32'h0 || bus2.dout !== 32'h0) begin failures++;
         $display("FAIL reset_dout got=%h/%h exp=0", bus1.dout, bus2.dout); end
      checks++; if (bus1.valid !== 1'b0 || bus2.valid !== 1'b0) begin failures++;
         $display("FAIL reset_valid got=%b/%b exp=0", bus1.valid, bus2.valid); end
      checks++; if (bus1.misalign !== 1'b0 || bus2.misalign !== 1'b0) begin failures++;
         $display("FAIL reset_misalign got=%b/%b exp=0", bus1.misalign, bus2.misalign); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      obs_t a, b;
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, a, b);
      checks++; if ({a.v1, a.v2, a.m1, a.m2, b.v1, b.v2} !== 6'b0) begin failures++;
         $display("FAIL sw_no_pulse got=%b exp=000000", {a.v1, a.v2, a.m1, a.m2, b.v1, b.v2}); end
      issue(1'b1, 2'd2, 1'b1, 12'h010, 32'h0, a, b);
      checks++; if ({a.v1, a.v2, b.v1, b.v2} !== 4'b1001) begin failures++;
         $display("FAIL lw_valid_timing got=%b exp=1001", {a.v1, a.v2, b.v1, b.v2}); end
      checks++; if (a.d1 !== 32'hDEADBEEF) begin failures++;
         $display("FAIL lw_lat1 got=%h exp=deadbeef", a.d1); end
      checks++; if (b.d2 !== 32'hDEADBEEF) begin failures++;
         $display("FAIL lw_lat2 got=%h exp=deadbeef", b.d2); end
      checks++; if (b.d1 !== 32'hDEADBEEF) begin failures++;
         $display("FAIL lw_hold got=%h exp=deadbeef", b.d1); end
   endtask

   task automatic test_byte();
      obs_t a, b;
      logic [31:0] exp_v [3];
      logic        sx_v  [3];
      logic [1:0]  sz_v  [3];
      logic [11:0] ad_v  [3];
      exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF};
      sx_v  = '{1'b1, 1'b0, 1'b1};
      sz_v  = '{2'd0, 2'd0, 2'd2};
      ad_v  = '{12'h011, 12'h011, 12'h010};
      issue(1'b0, 2'd0, 1'b0, 12'h011, 32'h12345680, a, b);
      for (int k = 0; k < 3; k++) begin
         issue(1'b1, sz_v[k], sx_v[k], ad_v[k], 32'h0, a, b);
         checks++; if ({a.v1, a.v2, b.v1, b.v2} !== 4'b1001) begin failures++;
            $display("FAIL byte_valid_%0d got=%b exp=1001", k, {a.v1, a.v2, b.v1, b.v2}); end
         checks++; if (a.d1 !== exp_v[k] || b.d2 !== exp_v[k]) begin failures++;
            $display("FAIL byte_load_%0d got=%h/%h exp=%h", k, a.d1, b.d2, exp_v[k]); end
      end
   endtask

   task automatic test_half();
      obs_t a, b;
      logic [31:0] exp_v [3];
      logic        sx_v  [3];
      logic [1:0]  sz_v  [3];
      logic [11:0] ad_v  [3];
      exp_v = '{32'hFFFF8001, 32'h00008001, 32'h800180EF};
      sx_v  = '{1'b1, 1'b0, 1'b0};
      sz_v  = '{2'd1, 2'd1, 2'd2};
      ad_v  = '{12'h012, 12'h012, 12'h010};
      issue(1'b0, 2'd1, 1'b0, 12'h012, 32'hABCD8001, a, b);
      for (int k = 0; k < 3; k++) begin
         issue(1'b1, sz_v[k], sx_v[k], ad_v[k], 32'h0, a, b);
         checks++; if ({a.v1, a.v2, b.v1, b.v2} !== 4'b1001) begin failures++;
            $display("FAIL half_valid_%0d got=%b exp=1001", k, {a.v1, a.v2, b.v1, b.v2}); end
         checks++; if (a.d1 !== exp_v[k] || b.d2 !== exp_v[k]) begin failures++;
            $display("FAIL half_load_%0d got=%h/%h exp=%h", k, a.d1, b.d2, exp_v[k]); end
      end
   endtask

   task automatic test_misalign();
      obs_t a, b;
      logic        wr_v [3];
      logic [1:0]  sz_v [3];
      logic [11:0] ad_v [3];
      wr_v = '{1'b1, 1'b0, 1'b0};
      sz_v = '{2'd2, 2'd1, 2'd3};
      ad_v = '{12'h013, 12'h011, 12'h010};
      for (int k = 0; k < 3; k++) begin
         issue(wr_v[k], sz_v[k], 1'b1, ad_v[k], 32'hFFFFFFFF, a, b);
         checks++; if ({a.m1, a.m2, a.v1, a.v2, b.m1, b.m2, b.v1, b.v2} !== 8'b11000000) begin failures++;
            $display("FAIL misalign_%0d got=%b exp=11000000", k, {a.m1, a.m2, a.v1, a.v2, b.m1, b.m2, b.v1, b.v2}); end
      end
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'h0, a, b);
      checks++; if (a.d1 !== 32'h800180EF || b.d2 !== 32'h800180EF) begin failures++;
         $display("FAIL misalign_mem_unchanged got=%h/%h exp=800180ef", a.d1, b.d2); end
   endtask

   task automatic test_back_to_back();
      obs_t o, b;
      logic [31:0] w [3];
      for (int k = 0; k < 3; k++) begin
         w[k] = $urandom;
         issue(1'b0, 2'd2, 1'b0, 12'(4*k), w[k], o, b);
      end
      // Three loads in consecutive cycles.
      set_req(1'b1, 1'b1, 2'd2, 1'b0, 12'h000, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         sample(o);
         checks++; if (o.v1 !== (k <= 3) || o.v2 !== (k >= 2)) begin failures++;
            $display("FAIL b2b_valid_%0d got=%b%b exp=%b%b", k, o.v1, o.v2, (k <= 3), (k >= 2)); end
         checks++; if (o.d1 !== w[(k <= 3) ? k - 1 : 2]) begin failures++;
            $display("FAIL b2b_lat1_%0d got=%h exp=%h", k, o.d1, w[(k <= 3) ? k - 1 : 2]); end
         if (k >= 2) begin
            checks++; if (o.d2 !== w[k - 2]) begin failures++;
               $display("FAIL b2b_lat2_%0d got=%h exp=%h", k, o.d2, w[k - 2]); end
         end
         if (k < 3) set_req(1'b1, 1'b1, 2'd2, 1'b0, 12'(4*k), 32'h0);
         else       idle();
      end
      // Same burst with reset asserted after the first latency-2 result.
      set_req(1'b1, 1'b1, 2'd2, 1'b0, 12'h000, 32'h0);
      @(negedge clk);
      set_req(1'b1, 1'b1, 2'd2, 1'b0, 12'h004, 32'h0);
      @(negedge clk);
      sample(o);
      checks++; if (o.v2 !== 1'b1 || o.d2 !== w[0]) begin failures++;
         $display("FAIL b2b_rst_first got=%b/%h exp=1/%h", o.v2, o.d2, w[0]); end
      set_req(1'b1, 1'b1, 2'd2, 1'b0, 12'h008, 32'h0);
      #1 rst = 1'b1;
      #1 sample(o);
      checks++; if ({o.v1, o.v2, o.m1, o.m2} !== 4'b0 || o.d1 !== 32'h0 || o.d2 !== 32'h0) begin failures++;
         $display("FAIL async_rst got=%b %h %h exp=0000 0 0", {o.v1, o.v2, o.m1, o.m2}, o.d1, o.d2); end
      @(negedge clk);
      rst = 1'b0;
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sample(o);
         checks++; if ({o.v1, o.v2} !== 2'b00 || o.d1 !== 32'h0 || o.d2 !== 32'h0) begin failures++;
            $display("FAIL rst_drop_%0d got=%b%b %h %h exp=00 0 0", k, o.v1, o.v2, o.d1, o.d2); end
      end
   endtask

   task automatic test_random();
      logic        ev1 [0:N+2];
      logic        ev2 [0:N+2];
      logic        em  [0:N+2];
      logic [31:0] ed1 [0:N+2];
      logic [31:0] ed2 [0:N+2];
      logic [31:0] last1, last2, r;
      logic        c, wr, sx;
      logic [1:0]  sz;
      logic [AW-1:0] a;
      int          pick;
      for (int i = 0; i <= N + 2; i++) begin
         ev1[i] = 1'b0; ev2[i] = 1'b0; em[i] = 1'b0; ed1[i] = '0; ed2[i] = '0;
      end
      for (int k = 0; k < 16; k++) begin
         r = $urandom;
         set_req(1'b1, 1'b0, 2'd2, 1'b0, 12'(4*k), r);
         model_store(2'd2, 12'(4*k), r);
         @(negedge clk);
      end
      idle();
      @(negedge clk);
      last1 = '0;
      last2 = '0;
      for (int i = 0; i <= N + 2; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (ev1[i]) last1 = ed1[i];
            if (ev2[i]) last2 = ed2[i];
            checks++; if (bus1.valid !== ev1[i] || bus1.dout !== last1 || bus1.misalign !== em[i]) begin failures++;
               $display("FAIL rnd_lat1 cyc=%0d got=%b/%h/%b exp=%b/%h/%b", i, bus1.valid, bus1.dout, bus1.misalign, ev1[i], last1, em[i]); end
            checks++; if (bus2.valid !== ev2[i] || bus2.dout !== last2 || bus2.misalign !== em[i]) begin failures++;
               $display("FAIL rnd_lat2 cyc=%0d got=%b/%h/%b exp=%b/%h/%b", i, bus2.valid, bus2.dout, bus2.misalign, ev2[i], last2, em[i]); end
         end
         if (i < N) begin
            c    = ($urandom_range(0, 7) != 0);
            wr   = 1'($urandom_range(0, 1));
            sx   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            sz   = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
            a    = 12'($urandom_range(0, 63));
            r    = $urandom;
            set_req(c, wr, sz, sx, a, r);
            if (c && model_aligned(sz, a)) begin
               if (!wr) model_store(sz, a, r);
               else begin
                  ev1[i + 1] = 1'b1; ed1[i + 1] = model_load(sz, sx, a);
                  ev2[i + 2] = 1'b1; ed2[i + 2] = model_load(sz, sx, a);
               end
            end else if (c) begin
               em[i + 1] = 1'b1;
            end
         end else begin
            idle();
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
